// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants (640x480@60 defaults), sync polarity
// names and small helpers used by the display blocks.
package vga_pkg;

   // Default 640x480@60 horizontal timing, in pixels
   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;

   // Default 640x480@60 vertical timing, in lines
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;

   // Sync pulse active level
   localparam bit ACTIVE_LOW  = 1'b0;
   localparam bit ACTIVE_HIGH = 1'b1;

   // Total period of one axis (visible + porches + sync)
   function automatic int unsigned timing_total(input int unsigned active,
                                                input int unsigned fp,
                                                input int unsigned sync,
                                                input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

   // MSB position of colour channel chan (0 = R top, 1 = G middle, 2 = B
   // bottom) in an rgb_w-bit word; R and G take the extra bits (e.g. 3-3-2).
   function automatic int unsigned chan_msb(input int unsigned rgb_w,
                                            input int unsigned chan);
      int unsigned b_w;
      int unsigned g_w;
      b_w = rgb_w / 3;
      g_w = (rgb_w + 1) / 3;
      case (chan)
         0:       return rgb_w - 1;
         1:       return b_w + g_w - 1;
         default: return b_w - 1;
      endcase
   endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// vga_pix_tick: generic clock-enable divider. tick is high for one clk cycle
// out of every CLK_DIV; CLK_DIV <= 1 gives a constant enable.
module vga_pix_tick #(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   generate
      if (CLK_DIV <= 1) begin : g_bypass
         assign tick = 1'b1;
      end else begin : g_div
         localparam int unsigned   DW   = $clog2(CLK_DIV);
         localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

         logic [DW-1:0] div;

         // Count 0..CLK_DIV-1 and wrap
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               div <= '0;
            else if (div == LAST)
               div <= '0;
            else
               div <= div + DW'(1);
         end

         assign tick = (div == LAST);
      end
   endgenerate

endmodule

// File: rtl/vga_driver_param.sv
// vga_driver_param: parametrised VGA timing generator. Produces registered
// H/V sync and blanked RGB one pixel period behind X_COORD/Y_COORD.
// Optional macro VGA_DRIVER_TEST_PATTERN_EN adds PATTERN_SEL, which replaces
// RGB_IN with eight internal colour bars across the visible line.
module vga_driver_param
   import vga_pkg::*;
#(
   parameter int unsigned RGB_W      = 8,
   parameter int unsigned COORD_W    = 10,
   parameter int unsigned CLK_DIV    = 2,
   parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
   parameter int unsigned H_FP       = DEF_H_FP,
   parameter int unsigned H_SYNC_LEN = DEF_H_SYNC,
   parameter int unsigned H_BP       = DEF_H_BP,
   parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
   parameter int unsigned V_FP       = DEF_V_FP,
   parameter int unsigned V_SYNC_LEN = DEF_V_SYNC,
   parameter int unsigned V_BP       = DEF_V_BP,
   parameter bit          H_POL      = ACTIVE_LOW,
   parameter bit          V_POL      = ACTIVE_LOW
) (
   input  logic               CLK_IN,
   input  logic               RST_IN,
`ifdef VGA_DRIVER_TEST_PATTERN_EN
   input  logic               PATTERN_SEL,
`endif
   input  logic [RGB_W-1:0]   RGB_IN,
   output logic               H_SYNC,
   output logic               V_SYNC,
   output logic [RGB_W-1:0]   RGB,
   output logic [COORD_W-1:0] X_COORD,
   output logic [COORD_W-1:0] Y_COORD,
   output logic               ACTIVE,
   output logic               PIX_TICK,
   output logic               FRAME_START
);

   localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC_LEN, H_BP);
   localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC_LEN, V_BP);

   localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);
   localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_ACTIVE + H_FP);
   localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC_LEN - 1);
   localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE + V_FP);
   localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC_LEN - 1);

   logic               pix_tick;
   logic [COORD_W-1:0] h_cnt;
   logic [COORD_W-1:0] v_cnt;
   logic               active;
   logic               hs_on;
   logic               vs_on;
   logic [RGB_W-1:0]   rgb_src;
   logic [RGB_W-1:0]   rgb_q;
   logic               hs_q;
   logic               vs_q;

   vga_pix_tick #(.CLK_DIV(CLK_DIV)) u_pix_tick (
      .clk  (CLK_IN),
      .rst  (RST_IN),
      .tick (pix_tick)
   );

   // Pixel and line counters, advancing once per pixel period
   always_ff @(posedge CLK_IN or posedge RST_IN) begin
      if (RST_IN) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_tick) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST)
               v_cnt <= '0;
            else
               v_cnt <= v_cnt + COORD_W'(1);
         end else begin
            h_cnt <= h_cnt + COORD_W'(1);
         end
      end
   end

`ifdef VGA_DRIVER_TEST_PATTERN_EN
   localparam int unsigned R_MSB = chan_msb(RGB_W, 0);
   localparam int unsigned G_MSB = chan_msb(RGB_W, 1);
   localparam int unsigned B_MSB = chan_msb(RGB_W, 2);
   localparam logic [COORD_W+2:0] BAR_DIV = (COORD_W + 3)'(H_ACTIVE);

   logic [2:0]       bar;
   logic [RGB_W-1:0] pattern;

   // Colour-bar source: bar index bit i lights the MSB of channel i
   always_comb begin
      bar            = 3'(({3'b000, h_cnt} << 3) / BAR_DIV);
      pattern        = '0;
      pattern[R_MSB] = bar[0];
      pattern[G_MSB] = bar[1];
      pattern[B_MSB] = bar[2];
      rgb_src        = PATTERN_SEL ? pattern : RGB_IN;
   end
`else
   // Colour source is always the external pixel source
   always_comb begin
      rgb_src = RGB_IN;
   end
`endif

   // Visible-area and sync-window decode from the current counters
   always_comb begin
      active = (h_cnt < H_VIS) && (v_cnt < V_VIS);
      hs_on  = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
      vs_on  = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
   end

   // Output stage: one pixel behind the counters, sync and colour aligned
   always_ff @(posedge CLK_IN or posedge RST_IN) begin
      if (RST_IN) begin
         rgb_q <= '0;
         hs_q  <= ~H_POL;
         vs_q  <= ~V_POL;
      end else if (pix_tick) begin
         rgb_q <= active ? rgb_src : '0;
         hs_q  <= hs_on ? H_POL : ~H_POL;
         vs_q  <= vs_on ? V_POL : ~V_POL;
      end
   end

   assign RGB         = rgb_q;
   assign H_SYNC      = hs_q;
   assign V_SYNC      = vs_q;
   assign X_COORD     = h_cnt;
   assign Y_COORD     = v_cnt;
   assign ACTIVE      = active;
   assign PIX_TICK    = pix_tick;
   assign FRAME_START = pix_tick & (h_cnt == '0) & (v_cnt == '0);

endmodule
